// File: rtl/adc_daq_pkg.sv
// Shared constants, FSM state type and counter-width helper for the ADC SPI capture path.
package adc_daq_pkg;

    localparam int unsigned SAMPLE_BITS_DEF   = 18;
    localparam int unsigned CLK_DIV_DEF       = 5;
    localparam int unsigned CS_SETUP_DEF      = 2;
    localparam int unsigned CS_HOLD_DEF       = 2;
    localparam int unsigned SAMPLE_PERIOD_DEF = 200;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        WAIT
    } fsm_state_t;

    // Bits needed for a counter that runs 0..n-1
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_sclk_divider.sv
// SCLK phase generator: CLK_DIV cycles low then CLK_DIV cycles high per bit while run is held.
module adc_sclk_divider
    import adc_daq_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic run,
    input  logic run_next,
    output logic sclk,
    output logic rise_phase_last
);

    localparam int unsigned PH_N = 2 * CLK_DIV;
    localparam int unsigned PH_W = cnt_w(PH_N);

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_next;

    // Phase restarts at 0 on the first SHIFT cycle and wraps every bit
    always_comb begin
        ph_next = '0;
        if (run && run_next) begin
            ph_next = (ph == PH_W'(PH_N - 1)) ? '0 : ph + PH_W'(1);
        end
    end

    // sclk is registered from the next phase so it lines up with ph
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            ph   <= '0;
            sclk <= 1'b0;
        end else begin
            ph   <= ph_next;
            sclk <= run_next && (ph_next >= PH_W'(CLK_DIV));
        end
    end

    assign rise_phase_last = run && (ph == PH_W'(PH_N - 1));

endmodule

// File: rtl/adc_spi_capture.sv
// SPI initiator for the 18-bit serial ADC: one frame per sample period, result on a valid/ready stream.
module adc_spi_capture
    import adc_daq_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS   = SAMPLE_BITS_DEF,
    parameter int unsigned CLK_DIV       = CLK_DIV_DEF,
    parameter int unsigned CS_SETUP      = CS_SETUP_DEF,
    parameter int unsigned CS_HOLD       = CS_HOLD_DEF,
    parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
    input  logic                   clk_100MHz,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   adc_dout,
    output logic                   adc_cs_n,
    output logic                   adc_sclk,
    output logic [SAMPLE_BITS-1:0] sample_data,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic                   busy
);

    localparam int unsigned PERIOD_W = cnt_w(SAMPLE_PERIOD);
    localparam int unsigned BIT_W    = cnt_w(SAMPLE_BITS);
    localparam int unsigned TCNT_N   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned TCNT_W   = cnt_w(TCNT_N);

    fsm_state_t              state;
    fsm_state_t              state_next;
    logic [PERIOD_W-1:0]     pcnt;
    logic [TCNT_W-1:0]       tcnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [SAMPLE_BITS-1:0]  shreg;
    logic                    dout_q;
    logic                    run;
    logic                    run_next;
    logic                    rise_last;
    logic                    period_end;
    logic                    deliver;
    logic                    frame_next;
    logic                    drop;

    assign period_end = (pcnt == PERIOD_W'(SAMPLE_PERIOD - 1));
    assign run        = (state == SHIFT);
    assign run_next   = (state_next == SHIFT);
    assign frame_next = (state_next == SETUP) || (state_next == SHIFT) || (state_next == HOLD);
    assign drop       = deliver && sample_valid && !sample_ready;

    adc_sclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk_100MHz      (clk_100MHz),
        .reset_n         (reset_n),
        .run             (run),
        .run_next        (run_next),
        .sclk            (adc_sclk),
        .rise_phase_last (rise_last)
    );

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        deliver    = 1'b0;
        case (state)
            IDLE:  if (enable) state_next = SETUP;
            SETUP: if (tcnt == TCNT_W'(CS_SETUP - 1)) state_next = SHIFT;
            SHIFT: if (rise_last && (bit_cnt == '0)) state_next = HOLD;
            HOLD: begin
                if (tcnt == TCNT_W'(CS_HOLD - 1)) begin
                    state_next = WAIT;
                    deliver    = 1'b1;
                end
            end
            WAIT:  if (period_end) state_next = enable ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame timing, serial capture and chip select
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            pcnt     <= '0;
            tcnt     <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            dout_q   <= 1'b0;
            adc_cs_n <= 1'b1;
            busy     <= 1'b0;
        end else begin
            dout_q   <= adc_dout;
            adc_cs_n <= !frame_next;
            busy     <= frame_next;

            if ((state == IDLE) || period_end) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PERIOD_W'(1);
            end

            if (state_next != state) begin
                tcnt <= '0;
            end else if ((state == SETUP) || (state == HOLD)) begin
                tcnt <= tcnt + TCNT_W'(1);
            end

            if (state != SHIFT) begin
                bit_cnt <= BIT_W'(SAMPLE_BITS - 1);
            end else if (rise_last) begin
                bit_cnt <= bit_cnt - BIT_W'(1);
            end

            if (rise_last) begin
                shreg <= {shreg[SAMPLE_BITS-2:0], dout_q};
            end
        end
    end

    // Output stream register; a delivery into a stalled slot is dropped and flagged
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (deliver && !drop) begin
                sample_data  <= shreg;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Self-checking bench for adc_spi_capture: serial ADC model, frame-timing reference model, directed + random tests.
module tb_adc_spi_capture;

    localparam int unsigned BITS    = 18;
    localparam int unsigned DIV     = 5;
    localparam int unsigned SETUP_C = 2;
    localparam int unsigned HOLD_C  = 2;
    localparam int unsigned PERIOD  = 200;
    localparam int unsigned T_SHEND = SETUP_C + 2 * DIV * BITS;
    localparam int unsigned T_CSUP  = T_SHEND + HOLD_C;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic            adc_dout = 1'b0;
    logic            adc_cs_n;
    logic            adc_sclk;
    logic [BITS-1:0] sample_data;
    logic            sample_valid;
    logic            sample_ready;
    logic            overrun;
    logic            overrun_clr;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    adc_spi_capture dut (
        .clk_100MHz   (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .adc_dout     (adc_dout),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ADC: loads a word on cs_n fall, presents MSB, advances on each SCLK fall
    logic [BITS-1:0] word_tab [16];
    int              wr_i = 0;
    int              rd_i = 0;
    logic [BITS-1:0] adc_sr = '0;
    logic [BITS-1:0] adc_frame_word = '0;
    logic            a_cs = 1'b1;
    logic            a_sclk = 1'b0;

    always @(posedge clk) begin
        #1;
        if (a_cs && !adc_cs_n) begin
            if (rd_i < wr_i) begin
                adc_frame_word = word_tab[rd_i];
                rd_i++;
            end else begin
                adc_frame_word = BITS'($urandom);
            end
            adc_sr = adc_frame_word;
        end else if (a_sclk && !adc_sclk) begin
            adc_sr = {adc_sr[BITS-2:0], 1'b0};
        end
        adc_dout = adc_sr[BITS-1];
        a_cs     = adc_cs_n;
        a_sclk   = adc_sclk;
    end

    task automatic push_word(input logic [BITS-1:0] w);
        word_tab[wr_i] = w;
        wr_i++;
    endtask

    // Reference model: position within the sample period decides pin levels; delivery at end of frame
    bit              m_idle = 1'b1;
    int              m_p = 0;
    bit              m_valid = 1'b0;
    bit              m_ovr = 1'b0;
    logic [BITS-1:0] m_data = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_idle  = 1'b1;
            m_p     = 0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_data  = '0;
        end else begin
            bit dlv;
            bit drp;
            dlv = !m_idle && (m_p == int'(T_CSUP) - 1);
            drp = dlv && m_valid && !sample_ready;
            if (dlv && !drp) begin
                m_data  = adc_frame_word;
                m_valid = 1'b1;
            end else if (m_valid && sample_ready) begin
                m_valid = 1'b0;
            end
            if (drp) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;

            if (m_idle) begin
                if (enable) begin
                    m_idle = 1'b0;
                    m_p    = 0;
                end
            end else if (m_p == int'(PERIOD) - 1) begin
                m_p    = 0;
                m_idle = !enable;
            end else begin
                m_p++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            bit e_cs;
            bit e_sclk;
            e_cs   = m_idle || (m_p >= int'(T_CSUP));
            e_sclk = !m_idle && (m_p >= int'(SETUP_C)) && (m_p < int'(T_SHEND)) &&
                     (((m_p - int'(SETUP_C)) % int'(2 * DIV)) >= int'(DIV));
            check("cs_n", 32'(adc_cs_n), 32'(e_cs));
            check("sclk", 32'(adc_sclk), 32'(e_sclk));
            check("busy", 32'(busy), 32'(!e_cs));
            check("valid", 32'(sample_valid), 32'(m_valid));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("data", 32'(sample_data), 32'(m_data));
        end
    end

    // Pin monitor: frame start cycles, SCLK rises per cs_n window, SCLK rise spacing
    int   cyc = 0;
    logic mon_cs = 1'b1;
    logic mon_sclk = 1'b0;
    int   rises = 0;
    int   last_rise = -1;
    int   first_int = -1;
    int   bad_int = 0;
    int   fall_cyc [$];
    int   rise_cnt [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_cs && !adc_cs_n) begin
            fall_cyc.push_back(cyc);
            rises     = 0;
            last_rise = -1;
        end
        if (!mon_sclk && adc_sclk) begin
            rises++;
            if (last_rise >= 0) begin
                if (first_int < 0) first_int = cyc - last_rise;
                if (cyc - last_rise != int'(2 * DIV)) bad_int++;
            end
            last_rise = cyc;
        end
        if (!mon_cs && adc_cs_n) rise_cnt.push_back(rises);
        mon_cs   = adc_cs_n;
        mon_sclk = adc_sclk;
    end

    // sel 0 waits on adc_cs_n, sel 1 on sample_valid
    task automatic wait_for(input int sel, input logic lvl, input int maxc, input string nm);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (((sel == 0) ? adc_cs_n : sample_valid) === lvl) return;
        end
        check({"timeout_", nm}, 32'(0), 32'(1));
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(adc_cs_n), 32'(1));
        check("rst_sclk", 32'(adc_sclk), 32'(0));
        check("rst_valid", 32'(sample_valid), 32'(0));
        check("rst_data", 32'(sample_data), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        chk_on  = 1'b1;
        reset_n = 1'b1;

        // full-scale word, then two patterns in consecutive frames
        push_word(18'h3FFFF);
        push_word(18'h2A5C3);
        push_word(18'h15A3C);
        @(negedge clk);
        enable = 1'b1;
        wait_for(1, 1'b1, 600, "t1_valid");
        check("t1_data", 32'(sample_data), 32'h3FFFF);
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(sample_valid), 32'(0));
        wait_for(1, 1'b1, 400, "t2_valid_a");
        check("t2_data_a", 32'(sample_data), 32'h2A5C3);
        wait_for(1, 1'b1, 400, "t2_valid_b");
        check("t2_data_b", 32'(sample_data), 32'h15A3C);
        if (fall_cyc.size() >= 3 && rise_cnt.size() >= 2) begin
            check("t2_frame_spacing_a", 32'(fall_cyc[1] - fall_cyc[0]), 32'd200);
            check("t2_frame_spacing_b", 32'(fall_cyc[2] - fall_cyc[1]), 32'd200);
            check("t2_sclk_rises_a", 32'(rise_cnt[0]), 32'd18);
            check("t2_sclk_rises_b", 32'(rise_cnt[1]), 32'd18);
        end else begin
            check("t2_frame_count", 32'(fall_cyc.size()), 32'd3);
        end
        check("t2_sclk_period_cycles", 32'(first_int), 32'd10);
        check("t2_sclk_period_errs", 32'(bad_int), 32'd0);

        // stall across two frames: first held, second dropped
        wait_for(1, 1'b0, 5, "t3_drain");
        sample_ready = 1'b0;
        push_word(18'h1B2C4);
        push_word(18'h24D3B);
        wait_for(1, 1'b1, 400, "t3_valid");
        check("t3_first_data", 32'(sample_data), 32'h1B2C4);
        wait_for(0, 1'b0, 400, "t3_cs_fall");
        wait_for(0, 1'b1, 400, "t3_cs_rise");
        check("t3_overrun_set", 32'(overrun), 32'(1));
        check("t3_data_held", 32'(sample_data), 32'h1B2C4);
        check("t3_valid_held", 32'(sample_valid), 32'(1));
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t3_overrun_clr", 32'(overrun), 32'(0));

        // ready asserted only on the delivery cycle
        push_word(18'h0F0F0);
        wait_for(0, 1'b0, 400, "t4_cs_fall");
        repeat (T_CSUP - 1) @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check("t4_valid", 32'(sample_valid), 32'(1));
        check("t4_data", 32'(sample_data), 32'h0F0F0);
        check("t4_no_overrun", 32'(overrun), 32'(0));
        sample_ready = 1'b1;

        // enable dropped at bit 9
        push_word(18'h30C0F);
        wait_for(0, 1'b0, 400, "t5_cs_fall");
        repeat (SETUP_C + 9 * 2 * DIV) @(negedge clk);
        enable = 1'b0;
        wait_for(0, 1'b1, 300, "t5_cs_rise");
        check("t5_valid", 32'(sample_valid), 32'(1));
        check("t5_data", 32'(sample_data), 32'h30C0F);
        begin
            int low_cycles = 0;
            for (int i = 0; i < 450; i++) begin
                @(negedge clk);
                if (adc_cs_n !== 1'b1) low_cycles++;
            end
            check("t5_cs_stays_high", 32'(low_cycles), 32'(0));
        end

        // reset at bit 5 aborts the frame
        push_word(18'h12345);
        push_word(18'h2DCBA);
        enable = 1'b1;
        wait_for(0, 1'b0, 10, "t6_cs_fall");
        repeat (SETUP_C + 5 * 2 * DIV) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_cs_n", 32'(adc_cs_n), 32'(1));
        check("t6_rst_sclk", 32'(adc_sclk), 32'(0));
        check("t6_rst_valid", 32'(sample_valid), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        wait_for(1, 1'b1, 400, "t6_valid");
        check("t6_data", 32'(sample_data), 32'h2DCBA);

        // random ready/clear/enable traffic with random ADC words
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            sample_ready = ($urandom_range(0, 3) != 0);
            overrun_clr  = ($urandom_range(0, 15) == 0);
            if (i % 300 == 0) enable = ($urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
